// File: rtl/instr_issue_unit_if.sv
// Instruction, memory and ALU handshake bundle for instr_issue_unit.
// The issue unit is the slave side; the environment (memory, ALU, instruction source) is the master.
interface instr_issue_unit_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 14,
    parameter int OP_W   = 4,
    parameter int RSEL_W = 1
);
    localparam int IW = OP_W + ADDR_W + RSEL_W;

    logic                  instr_valid;
    logic                  instr_ready;
    logic [IW-1:0]         instr;

    logic                  mem_load;
    logic                  mem_store;
    logic [ADDR_W-1:0]     mem_addr;
    logic [2*DATA_W-1:0]   mem_wdata;
    logic                  mem_done;
    logic [DATA_W-1:0]     mem_rdata;

    logic                  alu_start;
    logic [OP_W-1:0]       alu_op;
    logic [DATA_W-1:0]     alu_a;
    logic [DATA_W-1:0]     alu_b;
    logic                  alu_done;
    logic [2*DATA_W-1:0]   alu_result;

    logic                  done;
    logic                  busy;
    logic                  err;

    modport slave (
        input  instr_valid, instr, mem_done, mem_rdata, alu_done, alu_result,
        output instr_ready, mem_load, mem_store, mem_addr, mem_wdata,
               alu_start, alu_op, alu_a, alu_b, done, busy, err
    );

    modport master (
        output instr_valid, instr, mem_done, mem_rdata, alu_done, alu_result,
        input  instr_ready, mem_load, mem_store, mem_addr, mem_wdata,
               alu_start, alu_op, alu_a, alu_b, done, busy, err
    );
endinterface

// File: rtl/instr_issue_unit.sv
// In-order instruction issue unit: buffers instruction words in a small FIFO and issues them
// one at a time to a memory port or an ALU, tracking completion with a wait-cycle timeout.
module instr_issue_unit #(
    parameter int DATA_W   = 8,
    parameter int ADDR_W   = 14,
    parameter int OP_W     = 4,
    parameter int RSEL_W   = 1,
    parameter int DEPTH    = 4,
    parameter int TIMEOUT  = 64,
    parameter int OP_NOP   = 0,
    parameter int OP_LOAD  = 8,
    parameter int OP_STORE = 9
) (
    input  logic             clk,
    input  logic             reset,
    instr_issue_unit_if.slave bus
);
    localparam int IW   = OP_W + ADDR_W + RSEL_W;
    localparam int AW   = $clog2(DEPTH);
    localparam int CW   = $clog2(TIMEOUT) + 1;
    localparam int NREG = 2**RSEL_W;

    typedef enum logic [1:0] {IDLE, MEM_WAIT, ALU_WAIT} state_t;

    state_t              state_q, state_d;

    logic [IW-1:0]       fifo_mem [DEPTH];
    logic [AW-1:0]       wptr_q, wptr_d, rptr_q, rptr_d;
    logic [AW:0]         count_q, count_d;
    logic                full, push, pop;

    logic                mem_load_q, mem_load_d;
    logic                mem_store_q, mem_store_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [2*DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic                alu_start_q, alu_start_d;
    logic [OP_W-1:0]     alu_op_q, alu_op_d;
    logic [DATA_W-1:0]   alu_a_q, alu_a_d;
    logic [DATA_W-1:0]   alu_b_q, alu_b_d;
    logic                done_q, done_d;
    logic                err_q, err_d;
    logic [2*DATA_W-1:0] result_q, result_d;
    logic [RSEL_W-1:0]   rsel_q, rsel_d;
    logic [CW-1:0]       wcnt_q, wcnt_d;
    logic [DATA_W-1:0]   regs_q [NREG];
    logic                reg_we;

    logic [IW-1:0]       head;
    logic [OP_W-1:0]     h_op;
    logic [ADDR_W-1:0]   h_addr;
    logic [RSEL_W-1:0]   h_rsel, h_rsel_nx;

    assign head      = fifo_mem[rptr_q];
    assign h_op      = head[IW-1 -: OP_W];
    assign h_addr    = head[RSEL_W +: ADDR_W];
    assign h_rsel    = head[RSEL_W-1:0];
    assign h_rsel_nx = h_rsel + RSEL_W'(1);

    // Ready depends only on occupancy, so a full FIFO refuses a push even if it pops this cycle.
    assign full = (count_q == (AW+1)'(DEPTH));
    assign push = bus.instr_valid && !full;

    always_comb begin
        rptr_d  = rptr_q + AW'(pop);
        wptr_d  = wptr_q + AW'(push);
        count_d = count_q + (AW+1)'(push) - (AW+1)'(pop);
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wptr_q] <= bus.instr;
        end
    end

    always_comb begin
        state_d     = state_q;
        mem_load_d  = mem_load_q;
        mem_store_d = mem_store_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        alu_start_d = alu_start_q;
        alu_op_d    = alu_op_q;
        alu_a_d     = alu_a_q;
        alu_b_d     = alu_b_q;
        done_d      = 1'b0;
        err_d       = err_q;
        result_d    = result_q;
        rsel_d      = rsel_q;
        wcnt_d      = wcnt_q;
        pop         = 1'b0;
        reg_we      = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (count_q != '0) begin
                    pop    = 1'b1;
                    wcnt_d = '0;
                    if (h_op == OP_W'(OP_NOP)) begin
                        done_d = 1'b1;
                    end else if (h_op == OP_W'(OP_LOAD)) begin
                        mem_load_d = 1'b1;
                        mem_addr_d = h_addr;
                        rsel_d     = h_rsel;
                        state_d    = MEM_WAIT;
                    end else if (h_op == OP_W'(OP_STORE)) begin
                        mem_store_d = 1'b1;
                        mem_addr_d  = h_addr;
                        mem_wdata_d = result_q;
                        state_d     = MEM_WAIT;
                    end else begin
                        alu_start_d = 1'b1;
                        alu_op_d    = h_op;
                        alu_a_d     = regs_q[h_rsel];
                        alu_b_d     = regs_q[h_rsel_nx];
                        state_d     = ALU_WAIT;
                    end
                end
            end
            // Completion is tested before the timeout so a done on the last wait cycle still retires.
            MEM_WAIT: begin
                if (bus.mem_done) begin
                    mem_load_d  = 1'b0;
                    mem_store_d = 1'b0;
                    done_d      = 1'b1;
                    reg_we      = mem_load_q;
                    state_d     = IDLE;
                end else if (wcnt_q == CW'(TIMEOUT - 1)) begin
                    mem_load_d  = 1'b0;
                    mem_store_d = 1'b0;
                    err_d       = 1'b1;
                    state_d     = IDLE;
                end else begin
                    wcnt_d = wcnt_q + CW'(1);
                end
            end
            ALU_WAIT: begin
                if (bus.alu_done) begin
                    alu_start_d = 1'b0;
                    result_d    = bus.alu_result;
                    done_d      = 1'b1;
                    state_d     = IDLE;
                end else if (wcnt_q == CW'(TIMEOUT - 1)) begin
                    alu_start_d = 1'b0;
                    err_d       = 1'b1;
                    state_d     = IDLE;
                end else begin
                    wcnt_d = wcnt_q + CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            wptr_q      <= '0;
            rptr_q      <= '0;
            count_q     <= '0;
            mem_load_q  <= 1'b0;
            mem_store_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            alu_start_q <= 1'b0;
            alu_op_q    <= '0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            result_q    <= '0;
            rsel_q      <= '0;
            wcnt_q      <= '0;
        end else begin
            state_q     <= state_d;
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            count_q     <= count_d;
            mem_load_q  <= mem_load_d;
            mem_store_q <= mem_store_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            alu_start_q <= alu_start_d;
            alu_op_q    <= alu_op_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            done_q      <= done_d;
            err_q       <= err_d;
            result_q    <= result_d;
            rsel_q      <= rsel_d;
            wcnt_q      <= wcnt_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
        end else if (reg_we) begin
            regs_q[rsel_q] <= bus.mem_rdata;
        end
    end

    assign bus.instr_ready = !full;
    assign bus.mem_load    = mem_load_q;
    assign bus.mem_store   = mem_store_q;
    assign bus.mem_addr    = mem_addr_q;
    assign bus.mem_wdata   = mem_wdata_q;
    assign bus.alu_start   = alu_start_q;
    assign bus.alu_op      = alu_op_q;
    assign bus.alu_a       = alu_a_q;
    assign bus.alu_b       = alu_b_q;
    assign bus.done        = done_q;
    assign bus.err         = err_q;
    assign bus.busy        = (state_q != IDLE) || (count_q != '0);
endmodule

// File: tb/tb_instr_issue_unit.sv
// Bench for instr_issue_unit: directed scenarios plus randomized traffic, all checked each cycle
// against a queue-based transaction model of the issue unit.
module tb_instr_issue_unit;
    localparam int DATA_W = 8, ADDR_W = 14, OP_W = 4, RSEL_W = 1, DEPTH = 4, TIMEOUT = 64;
    localparam int OP_NOP = 0, OP_LOAD = 8, OP_STORE = 9;
    localparam int IW = OP_W + ADDR_W + RSEL_W;
    localparam int NREG = 2**RSEL_W;
    localparam int NEVER = 100000;

    logic clk = 1'b0;
    logic reset = 1'b1;

    instr_issue_unit_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .OP_W(OP_W), .RSEL_W(RSEL_W)) bus();

    instr_issue_unit #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .OP_W(OP_W), .RSEL_W(RSEL_W),
        .DEPTH(DEPTH), .TIMEOUT(TIMEOUT), .OP_NOP(OP_NOP), .OP_LOAD(OP_LOAD), .OP_STORE(OP_STORE)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int n_done  = 0;

    // Transaction model: pending queue, register file, and the single instruction in flight.
    logic [IW-1:0]       mq[$];
    logic [DATA_W-1:0]   m_regs [NREG];
    logic [2*DATA_W-1:0] m_result;
    bit                  m_err, m_inflight, m_done, m_pushed;
    int                  m_kind;  // 0 load, 1 store, 2 alu
    logic [ADDR_W-1:0]   m_addr;
    logic [RSEL_W-1:0]   m_rsel;
    logic [OP_W-1:0]     m_op;
    logic [DATA_W-1:0]   m_a, m_b;
    logic [2*DATA_W-1:0] m_wdata;
    int                  m_waited, m_lat;

    bit                  rand_mode = 1'b0;
    bit                  late_done = 1'b0;
    int                  fixed_lat = 3;
    logic [DATA_W-1:0]   fix_rdata = '0;
    logic [2*DATA_W-1:0] fix_result = '0;
    bit                  prev_load = 1'b0;
    logic [ADDR_W-1:0]   issue_log[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic timeout_fail(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: bounded wait expired at t=%0t", name, $time);
    endtask

    function automatic logic [IW-1:0] mk(input int op, input int addr, input int rsel);
        return {OP_W'(op), ADDR_W'(addr), RSEL_W'(rsel)};
    endfunction

    function automatic void model_reset();
        mq.delete();
        for (int i = 0; i < NREG; i++) m_regs[i] = '0;
        m_result   = '0;
        m_err      = 1'b0;
        m_inflight = 1'b0;
        m_done     = 1'b0;
        m_waited   = 0;
    endfunction

    function automatic int pick_lat();
        int r;
        if (!rand_mode) return fixed_lat;
        r = $urandom_range(0, 15);
        if (r == 0) return NEVER;
        if (r == 1) return TIMEOUT;
        return $urandom_range(1, 6);
    endfunction

    // Advance the model by one clock edge, using the inputs the DUT just sampled.
    function automatic void model_step();
        bit            can_push;
        logic [IW-1:0] w;
        int            op;
        can_push = (mq.size() < DEPTH);
        m_done   = 1'b0;
        m_pushed = 1'b0;
        if (reset) begin
            model_reset();
            return;
        end
        if (!m_inflight) begin
            if (mq.size() > 0) begin
                w  = mq.pop_front();
                op = int'(w[IW-1 -: OP_W]);
                if (op == OP_NOP) begin
                    m_done = 1'b1;
                end else begin
                    m_inflight = 1'b1;
                    m_waited   = 0;
                    m_lat      = pick_lat();
                    m_op       = w[IW-1 -: OP_W];
                    m_addr     = w[RSEL_W +: ADDR_W];
                    m_rsel     = w[RSEL_W-1:0];
                    if (op == OP_LOAD) begin
                        m_kind = 0;
                    end else if (op == OP_STORE) begin
                        m_kind  = 1;
                        m_wdata = m_result;
                    end else begin
                        m_kind = 2;
                        m_a    = m_regs[m_rsel];
                        m_b    = m_regs[(int'(m_rsel) + 1) % NREG];
                    end
                end
            end
        end else begin
            m_waited++;
            if (m_kind != 2 && bus.mem_done) begin
                if (m_kind == 0) m_regs[m_rsel] = bus.mem_rdata;
                m_done     = 1'b1;
                m_inflight = 1'b0;
            end else if (m_kind == 2 && bus.alu_done) begin
                m_result   = bus.alu_result;
                m_done     = 1'b1;
                m_inflight = 1'b0;
            end else if (m_waited == TIMEOUT) begin
                m_err      = 1'b1;
                m_inflight = 1'b0;
            end
        end
        if (bus.instr_valid && can_push) begin
            mq.push_back(bus.instr);
            m_pushed = 1'b1;
        end
    endfunction

    task automatic check_outputs();
        bit el, es, ea;
        el = m_inflight && m_kind == 0;
        es = m_inflight && m_kind == 1;
        ea = m_inflight && m_kind == 2;
        check("mem_load",    64'(bus.mem_load),    64'(el));
        check("mem_store",   64'(bus.mem_store),   64'(es));
        check("alu_start",   64'(bus.alu_start),   64'(ea));
        check("done",        64'(bus.done),        64'(m_done));
        check("err",         64'(bus.err),         64'(m_err));
        check("busy",        64'(bus.busy),        64'(m_inflight || mq.size() > 0));
        check("instr_ready", 64'(bus.instr_ready), 64'(mq.size() < DEPTH));
        if (el || es) check("mem_addr", 64'(bus.mem_addr), 64'(m_addr));
        if (es)       check("mem_wdata", 64'(bus.mem_wdata), 64'(m_wdata));
        if (ea) begin
            check("alu_op", 64'(bus.alu_op), 64'(m_op));
            check("alu_a",  64'(bus.alu_a),  64'(m_a));
            check("alu_b",  64'(bus.alu_b),  64'(m_b));
        end
        if (bus.done === 1'b1) n_done++;
        if (bus.mem_load === 1'b1 && !prev_load) issue_log.push_back(bus.mem_addr);
        prev_load = (bus.mem_load === 1'b1);
    endtask

    // Environment responder: completes the in-flight request after its latency, plus stray dones.
    task automatic respond();
        bus.mem_done = 1'b0;
        bus.alu_done = late_done;
        if (rand_mode) begin
            bus.mem_rdata  = DATA_W'($urandom);
            bus.alu_result = (2*DATA_W)'($urandom);
        end else begin
            bus.mem_rdata  = fix_rdata;
            bus.alu_result = fix_result;
        end
        if (m_inflight && (m_waited + 1 == m_lat)) begin
            if (m_kind == 2) bus.alu_done = 1'b1;
            else             bus.mem_done = 1'b1;
        end
        if (rand_mode && $urandom_range(0, 7) == 0) begin
            if (!m_inflight) begin
                bus.mem_done = 1'($urandom_range(0, 1));
                bus.alu_done = 1'($urandom_range(0, 1));
            end else if (m_kind == 2) begin
                bus.mem_done = 1'b1;
            end else begin
                bus.alu_done = 1'b1;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check_outputs();
        respond();
    endtask

    task automatic push(input logic [IW-1:0] w);
        bus.instr       = w;
        bus.instr_valid = 1'b1;
        for (int i = 0; i < 200; i++) begin
            tick();
            if (m_pushed) break;
        end
        if (!m_pushed) timeout_fail("push_accept");
        bus.instr_valid = 1'b0;
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 500; i++) begin
            if (!m_inflight && mq.size() == 0) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        if (!ok) timeout_fail("wait_idle");
    endtask

    task automatic check_reset_outputs();
        check("rst_mem_load",    64'(bus.mem_load),    64'd0);
        check("rst_mem_store",   64'(bus.mem_store),   64'd0);
        check("rst_alu_start",   64'(bus.alu_start),   64'd0);
        check("rst_done",        64'(bus.done),        64'd0);
        check("rst_err",         64'(bus.err),         64'd0);
        check("rst_busy",        64'(bus.busy),        64'd0);
        check("rst_instr_ready", 64'(bus.instr_ready), 64'd1);
        check("rst_mem_addr",    64'(bus.mem_addr),    64'd0);
        check("rst_mem_wdata",   64'(bus.mem_wdata),   64'd0);
        check("rst_alu_op",      64'(bus.alu_op),      64'd0);
        check("rst_alu_a",       64'(bus.alu_a),       64'd0);
        check("rst_alu_b",       64'(bus.alu_b),       64'd0);
    endtask

    // Asserts reset mid-cycle, checks outputs immediately, holds it two edges, then releases.
    task automatic do_reset();
        reset           = 1'b1;
        bus.instr_valid = 1'b0;
        model_reset();
        #1;
        check_reset_outputs();
        tick();
        tick();
        reset = 1'b0;
    endtask

    function automatic logic [IW-1:0] rand_instr();
        int r, op;
        r = $urandom_range(0, 7);
        if (r < 2)       op = OP_NOP;
        else if (r < 4)  op = OP_LOAD;
        else if (r == 4) op = OP_STORE;
        else begin
            op = $urandom_range(1, 15);
            while (op == OP_LOAD || op == OP_STORE) op = $urandom_range(1, 15);
        end
        return mk(op, int'($urandom_range(0, (1 << ADDR_W) - 1)), int'($urandom_range(0, NREG - 1)));
    endfunction

    initial begin
        #800000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int n0, cnt;
        bus.instr_valid = 1'b0;
        bus.instr       = '0;
        bus.mem_done    = 1'b0;
        bus.mem_rdata   = '0;
        bus.alu_done    = 1'b0;
        bus.alu_result  = '0;
        model_reset();

        repeat (3) tick();
        check_reset_outputs();
        reset = 1'b0;
        tick();

        // Two loads with 3-cycle memory latency.
        n_done    = 0;
        fixed_lat = 3;
        fix_rdata = 8'h05;
        push(mk(OP_LOAD, 14'h0123, 0));
        tick();
        check("lit_load0_issue", 64'(bus.mem_load), 64'd1);
        check("lit_load0_addr",  64'(bus.mem_addr), 64'h0123);
        wait_idle();
        fix_rdata = 8'h07;
        push(mk(OP_LOAD, 14'h0124, 1));
        tick();
        check("lit_load1_addr",  64'(bus.mem_addr), 64'h0124);
        wait_idle();
        check("lit_two_dones", 64'(n_done), 64'd2);

        // ALU op 1 on reg0/reg1, then store its result.
        fix_result = 16'h000C;
        push(mk(1, 0, 0));
        tick();
        check("lit_alu_op", 64'(bus.alu_op), 64'd1);
        check("lit_alu_a",  64'(bus.alu_a),  64'd5);
        check("lit_alu_b",  64'(bus.alu_b),  64'd7);
        tick();
        check("lit_alu_a_held", 64'(bus.alu_a), 64'd5);
        check("lit_alu_b_held", 64'(bus.alu_b), 64'd7);
        wait_idle();
        push(mk(OP_STORE, 14'h0200, 0));
        tick();
        check("lit_store_addr",  64'(bus.mem_addr),  64'h0200);
        check("lit_store_wdata", 64'(bus.mem_wdata), 64'h000C);
        wait_idle();

        // Six back-to-back loads with slow memory: FIFO fills, order preserved.
        fixed_lat = 10;
        n_done    = 0;
        issue_log.delete();
        for (int i = 0; i < 6; i++) begin
            push(mk(OP_LOAD, 'h300 + i, i % NREG));
            if (i == 4) check("lit_fifo_full_ready", 64'(bus.instr_ready), 64'd0);
        end
        wait_idle();
        check("lit_b2b_dones", 64'(n_done), 64'd6);
        check("lit_issue_count", 64'(issue_log.size()), 64'd6);
        for (int i = 0; i < 6 && i < issue_log.size(); i++)
            check("lit_issue_order", 64'(issue_log[i]), 64'('h300 + i));

        // Load that never completes: times out after TIMEOUT wait cycles, next instruction proceeds.
        fixed_lat = NEVER;
        n0 = n_done;
        push(mk(OP_LOAD, 14'h03AA, 0));
        push(mk(OP_NOP, 0, 0));
        cnt = (bus.mem_load === 1'b1) ? 1 : 0;
        for (int i = 0; i < 200; i++) begin
            tick();
            if (bus.mem_load === 1'b1) cnt++;
            else if (cnt > 0) break;
        end
        check("lit_timeout_len", 64'(cnt), 64'(TIMEOUT));
        check("lit_timeout_err", 64'(bus.err), 64'd1);
        wait_idle();
        repeat (2) tick();
        check("lit_timeout_only_nop_done", 64'(n_done - n0), 64'd1);
        check("lit_err_sticky", 64'(bus.err), 64'd1);

        // Done on the very last wait cycle wins over the timeout.
        do_reset();
        fixed_lat = TIMEOUT;
        n0 = n_done;
        push(mk(OP_LOAD, 14'h0055, 1));
        wait_idle();
        check("lit_tie_done", 64'(n_done - n0), 64'd1);
        check("lit_tie_err",  64'(bus.err), 64'd0);

        // Reset during ALU wait, late alu_done ignored, then a NOP retires once.
        fixed_lat = NEVER;
        push(mk(3, 0, 1));
        tick();
        tick();
        check("lit_in_alu_wait", 64'(bus.alu_start), 64'd1);
        late_done = 1'b1;
        do_reset();
        tick();
        late_done = 1'b0;
        fixed_lat = 3;
        n0 = n_done;
        push(mk(OP_NOP, 0, 0));
        repeat (5) tick();
        check("lit_nop_single_done", 64'(n_done - n0), 64'd1);

        // Randomized traffic with stray dones, timeouts and occasional resets.
        rand_mode = 1'b1;
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 499) == 0) begin
                do_reset();
            end else begin
                bus.instr_valid = ($urandom_range(0, 2) != 0);
                bus.instr       = rand_instr();
                tick();
            end
        end
        bus.instr_valid = 1'b0;
        wait_idle();
        repeat (3) tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/instr_issue_unit.md
INSTR_ISSUE_UNIT -- requirements
Module: instr_issue_unit

Interface
REQ-001 Parameter DATA_W, default 8: operand width; ALU result and store data are 2*DATA_W.
REQ-002 Parameter ADDR_W, default 14: memory address width.
REQ-003 Parameter OP_W, default 4: opcode field width.
REQ-004 Parameter RSEL_W, default 1: register-select width; register count NREG = 2**RSEL_W.
REQ-005 Parameter DEPTH, default 4: instruction FIFO entries (power of 2, >=2).
REQ-006 Parameter TIMEOUT, default 64: wait-state cycle limit (>=2).
REQ-007 Parameters OP_NOP=0, OP_LOAD=8, OP_STORE=9: opcode encodings; every other code is an ALU op.
REQ-008 Instruction word IW = OP_W+ADDR_W+RSEL_W bits, laid out {op, addr, rsel} MSB to LSB.
REQ-009 clk  in  1  single clock, rising edge.
REQ-010 reset  in  1  asynchronous, active-high reset.
REQ-011 instr_valid  in  1  instruction offered; instr_ready  out  1  FIFO not full; instr  in  IW  instruction word.
REQ-012 mem_load, mem_store  out  1 each  memory requests; mem_addr  out  ADDR_W; mem_wdata  out  2*DATA_W.
REQ-013 mem_done  in  1  memory op complete; mem_rdata  in  DATA_W  load data, valid with mem_done.
REQ-014 alu_start  out  1; alu_op  out  OP_W; alu_a, alu_b  out  DATA_W; alu_done  in  1; alu_result  in  2*DATA_W.
REQ-015 done  out  1  one-cycle pulse per retired instruction; busy  out  1  state != IDLE or FIFO non-empty; err  out  1  sticky timeout flag.

Function
REQ-016 FIFO push on instr_valid && instr_ready; instr_ready = !full, independent of pop in the same cycle; push and pop in one cycle both take effect.
REQ-017 FSM states IDLE, MEM_WAIT, ALU_WAIT; all outputs registered.
REQ-018 IDLE with FIFO non-empty: pop head at the clock edge and issue per REQ-019..022; an instruction pushed into an empty FIFO at edge k issues at edge k+1.
REQ-019 OP_LOAD: mem_load=1, mem_addr=addr, latch rsel -> MEM_WAIT.
REQ-020 OP_STORE: mem_store=1, mem_addr=addr, mem_wdata=result register -> MEM_WAIT.
REQ-021 ALU op: alu_start=1, alu_op=op, alu_a=reg[rsel], alu_b=reg[(rsel+1) mod NREG] -> ALU_WAIT.
REQ-022 OP_NOP: done=1 on the next cycle; stay in IDLE.
REQ-023 Requests (mem_load/mem_store/alu_start) and their address/operands hold steady until the matching done is sampled high.
REQ-024 MEM_WAIT && mem_done: at that edge clear the request, pulse done, write mem_rdata to reg[rsel] on a load -> IDLE.
REQ-025 ALU_WAIT && alu_done: at that edge clear alu_start, capture alu_result into the result register, pulse done -> IDLE.
REQ-026 Back-to-back issue: next instruction issues one cycle after the return to IDLE.
REQ-027 mem_done/alu_done sampled outside their matching wait state are ignored.
REQ-028 Wait-cycle counter clears on issue and increments each wait cycle.
REQ-029 Timeout: on the TIMEOUT-th wait cycle without done, clear the request, set err, no done pulse, no register write -> IDLE.
REQ-030 err clears only on reset; instruction processing continues while err is set.
REQ-031 A done arriving in the same cycle as the timeout wins: normal completion, err unchanged.

Reset
REQ-032 reset asserted, at any time, forces IDLE, an empty FIFO (instr_ready=1), and all registers and the result register to 0.
REQ-033 reset asserted forces mem_load, mem_store, alu_start, done, err and busy to 0, and mem_addr, mem_wdata, alu_op, alu_a and alu_b to 0.
REQ-034 reset mid-operation abandons the in-flight instruction with no done pulse; the first issue occurs no earlier than the second rising edge after reset deasserts.

Verification
REQ-035 LOAD rsel=0 addr=0x0123, mem_done with mem_rdata=0x05 after 3 cycles; LOAD rsel=1 addr=0x0124, rdata=0x07 -> mem_addr matches, reg0=5, reg1=7, two done pulses.
REQ-036 Then ALU op 1 rsel=0, alu_done with alu_result=0x000C -> alu_a=5, alu_b=7 held until done; STORE addr=0x0200 -> mem_wdata=0x000C.
REQ-037 Push 6 instructions back-to-back with mem_done withheld -> instr_ready low after 4 are buffered; the remaining 2 accepted as pops free entries; issue order is preserved.
REQ-038 LOAD with mem_done never asserted -> mem_load drops after 64 wait cycles, err=1, no done pulse, next instruction issues; done on cycle 64 instead -> err stays 0.
REQ-039 Assert reset during ALU_WAIT -> all outputs 0 immediately, FIFO empty, a late alu_done ignored, NOP after reset -> single done pulse.
